// File: rtl/pp_accumulator_if.sv
// Handshake bundle between the 4x4 partial-product array and the
// partial-product accumulator: one input set, one product out.
interface pp_accumulator_if #(
    parameter int PW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   q0;
    logic [PW-1:0]   q1;
    logic [PW-1:0]   q2;
    logic [PW-1:0]   q3;
    logic            out_valid;
    logic            out_ready;
    logic [2*PW-1:0] out_data;
    logic            err;

    modport master (
        output in_valid,
        output q0,
        output q1,
        output q2,
        output q3,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  err
    );

    modport slave (
        input  in_valid,
        input  q0,
        input  q1,
        input  q2,
        input  q3,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output err
    );
endinterface

// File: rtl/pp_accumulator.sv
// Sums four weighted partial products over three cycles on one shared adder.
// Optional partial-range checker: define PP_ACC_CHECK_EN.
module pp_accumulator #(
    parameter int PW = 8
) (
    input logic             clk,
    input logic             rst,
    pp_accumulator_if.slave bus
);
    localparam int H = PW / 2;
    localparam int W = 2 * PW;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    step;
    logic [PW-1:0] r1;
    logic [PW-1:0] r2;
    logic [PW-1:0] r3;
    logic [W-1:0]  acc;
    logic [W-1:0]  add_b;
    logic [W-1:0]  sum;
    logic          accept;

    // Handshake outputs depend on registered state only (rst gates ready).
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = acc;
    assign accept        = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = ACC;
            ACC:     if (step == 2'd3) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        add_b = '0;
        unique case (1'b1)
            step == 2'd1: add_b = W'(r1) << H;
            step == 2'd2: add_b = W'(r2) << H;
            step == 2'd3: add_b = W'(r3) << PW;
            default:      add_b = '0;
        endcase
    end

    // Top carry is dropped; legal partials never reach it.
    assign sum = acc + add_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            step <= '0;
            r1   <= '0;
            r2   <= '0;
            r3   <= '0;
        end else if (accept) begin
            acc  <= W'(bus.q0);
            r1   <= bus.q1;
            r2   <= bus.q2;
            r3   <= bus.q3;
            step <= 2'd1;
        end else if (state == ACC) begin
            acc  <= sum;
            step <= step + 2'd1;
        end
    end

`ifdef PP_ACC_CHECK_EN
    localparam logic [PW-1:0] LIM =
        PW'(((1 << H) - 1) * ((1 << H) - 1));

    logic err_q;
    logic over;

    assign over = (bus.q0 > LIM) || (bus.q1 > LIM) ||
                  (bus.q2 > LIM) || (bus.q3 > LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         err_q <= 1'b0;
        else if (accept) err_q <= over;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_pp_accumulator.sv
// Directed bench for pp_accumulator: products, latency, backpressure,
// back-to-back throughput, mid-accumulation reset and range checking.
module tb_pp_accumulator;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

`ifdef PP_ACC_CHECK_EN
    localparam logic ERR_BIG = 1'b1;
`else
    localparam logic ERR_BIG = 1'b0;
`endif

    pp_accumulator_if #(.PW(PW)) bus ();

    pp_accumulator #(.PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        bus.q0 = a;
        bus.q1 = b;
        bus.q2 = c;
        bus.q3 = d;
    endtask

    // Present a set, wait for ready, then scramble inputs after accept.
    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        int n;
        n = 0;
        drive(a, b, c, d);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", 32'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        drive(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic run(input string name,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d,
                       input logic [15:0] exp, input logic exp_err);
        int lat;
        bus.out_ready = 1'b1;
        send(a, b, c, d);
        wait_valid(lat);
        check({name, "_latency"}, lat, 3);
        check({name, "_data"}, 32'(bus.out_data), 32'(exp));
        check({name, "_err"}, 32'(bus.err), 32'(exp_err));
        tick();
        check({name, "_idle_ready"}, 32'(bus.in_ready), 1);
        check({name, "_idle_valid"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
        int lat;
        int acc_at[2];
        int acc_cnt;
        int got_cnt;
        logic rdy;
        logic [15:0] got[2];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(8'h00, 8'h00, 8'h00, 8'h00);

        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_err", 32'(bus.err), 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(bus.in_ready), 1);

        run("nominal", 8'h8F, 8'h82, 8'h84, 8'h78, 16'h88EF, 1'b0);
        run("max", 8'hE1, 8'hE1, 8'hE1, 8'hE1, 16'hFE01, 1'b0);
        run("chk", 8'h10, 8'hFF, 8'h20, 8'h30, 16'h4200, ERR_BIG);
        run("zero", 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0);

        // Backpressure with a stray in_valid pulse while holding.
        bus.out_ready = 1'b0;
        send(8'h8F, 8'h82, 8'h84, 8'h78);
        wait_valid(lat);
        check("bp_latency", lat, 3);
        check("bp_data", 32'(bus.out_data), 32'h88EF);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                drive(8'h01, 8'h01, 8'h01, 8'h01);
                bus.in_valid = 1'b1;
            end
            if (i == 5) bus.in_valid = 1'b0;
            tick();
            check("bp_hold_data", 32'(bus.out_data), 32'h88EF);
            check("bp_hold_ready", 32'(bus.in_ready), 0);
            check("bp_hold_valid", 32'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_ready", 32'(bus.in_ready), 1);
        check("bp_release_valid", 32'(bus.out_valid), 0);
        tick();
        check("bp_no_ghost", 32'(bus.in_ready), 1);

        // Back-to-back: in_valid held high across two sets.
        acc_cnt = 0;
        got_cnt = 0;
        acc_at  = '{0, 0};
        got     = '{16'h0, 16'h0};
        drive(8'h8F, 8'h82, 8'h84, 8'h78);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 30 && got_cnt < 2; i++) begin
            rdy = bus.in_ready;
            tick();
            if (rdy && bus.in_valid) begin
                acc_at[acc_cnt] = cyc;
                acc_cnt++;
                if (acc_cnt == 1) drive(8'h01, 8'h02, 8'h03, 8'h04);
                else bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                got[got_cnt] = bus.out_data;
                got_cnt++;
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_accepts", acc_cnt, 2);
        check("b2b_spacing", acc_at[1] - acc_at[0], 5);
        check("b2b_data0", 32'(got[0]), 32'h88EF);
        check("b2b_data1", 32'(got[1]), 32'h0451);

        // Reset while the accumulation is at step 2.
        tick();
        send(8'hE1, 8'hE1, 8'hE1, 8'hE1);
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_data", 32'(bus.out_data), 0);
        check("mid_rst_ready", 32'(bus.in_ready), 0);
        check("mid_rst_err", 32'(bus.err), 0);
        tick();
        tick();
        check("mid_rst_hold_valid", 32'(bus.out_valid), 0);
        rst = 1'b0;
        tick();
        check("mid_rst_release", 32'(bus.in_ready), 1);
        run("after_rst", 8'h01, 8'h02, 8'h03, 8'h04, 16'h0451, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
